// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that captures a word from the fabric for the PowerPC to read back,
// with a sticky new-data flag and a saturating overflow counter.
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h01000B00,
   parameter logic [31:0] C_HIGHADDR   = 32'h01000BFF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   input  logic [31:0]               user_data_in,
   input  logic                      user_valid
);

   localparam int unsigned unused_family_bits = $bits(C_FAMILY);

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e      state_q, state_d;
   logic        rnw_q, rnw_d;
   logic        stat_sel_q, stat_sel_d;
   logic [31:0] hold_q, hold_d;
   logic        new_data_q, new_data_d;
   logic [15:0] ovf_q, ovf_d;
   logic [31:0] dbus_q, dbus_d;

   logic hit, ack, data_rd_ack, status_clr, ovf_inc;
   logic unused_inputs;

   assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-2]};

   assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

   // State register
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hit) state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      ack        = (state_q == StAck);
      Sl_xferAck = ack;
   end

   assign data_rd_ack = ack && rnw_q && !stat_sel_q;
   // Value bit 0 travels on big-endian bit C_OPB_DWIDTH-1.
   assign status_clr  = ack && !rnw_q && stat_sel_q && OPB_DBus[C_OPB_DWIDTH-1];
   assign ovf_inc     = user_valid && new_data_q && !data_rd_ack;

   always_comb begin
      rnw_d      = rnw_q;
      stat_sel_d = stat_sel_q;
      if (state_q == StIdle && hit) begin
         rnw_d      = OPB_RNW;
         stat_sel_d = OPB_ABus[C_OPB_AWIDTH-3];
      end

      hold_d = user_valid ? user_data_in : hold_q;

      new_data_d = new_data_q;
      if (user_valid) begin
         new_data_d = 1'b1;
      end else if (data_rd_ack) begin
         new_data_d = 1'b0;
      end

      // A clear racing an overflow keeps that overflow instead of dropping it.
      ovf_d = ovf_q;
      if (status_clr) begin
         ovf_d = {15'b0, ovf_inc};
      end else if (ovf_inc && ovf_q != 16'hFFFF) begin
         ovf_d = ovf_q + 16'd1;
      end

      // Read data is loaded on the hit edge so it sits on the bus only during the ack.
      dbus_d = 32'b0;
      if (state_q == StIdle && hit && OPB_RNW) begin
         dbus_d = OPB_ABus[C_OPB_AWIDTH-3] ? {ovf_d, 15'b0, new_data_d} : hold_d;
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         rnw_q      <= 1'b0;
         stat_sel_q <= 1'b0;
         hold_q     <= 32'b0;
         new_data_q <= 1'b0;
         ovf_q      <= 16'b0;
         dbus_q     <= 32'b0;
      end else begin
         rnw_q      <= rnw_d;
         stat_sel_q <= stat_sel_d;
         hold_q     <= hold_d;
         new_data_q <= new_data_d;
         ovf_q      <= ovf_d;
         dbus_q     <= dbus_d;
      end
   end

   assign Sl_DBus    = dbus_q;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: a table of OPB transfers and captures
// checked through a read-data scoreboard, plus hand-written decode/saturation sequences.
module tb_opb_register_simulink2ppc_snap;

   localparam logic [31:0] AData   = 32'h01000B00;
   localparam logic [31:0] AStatus = 32'h01000B04;

   localparam int OpCap   = 0;
   localparam int OpRead  = 1;
   localparam int OpWrite = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus_in;
   logic        rnw;
   logic        select;
   logic        seq_addr;
   logic [0:31] sl_dbus;
   logic        sl_err_ack, sl_retry, sl_tout_sup, sl_xfer_ack;
   logic [31:0] udata;
   logic        uvalid;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      string       name;
      int          op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      bit          uv_ack;
      logic [31:0] uv_data;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk      (clk),
      .OPB_Rst_n    (rst_n),
      .OPB_ABus     (abus),
      .OPB_BE       (be),
      .OPB_DBus     (dbus_in),
      .OPB_RNW      (rnw),
      .OPB_select   (select),
      .OPB_seqAddr  (seq_addr),
      .Sl_DBus      (sl_dbus),
      .Sl_errAck    (sl_err_ack),
      .Sl_retry     (sl_retry),
      .Sl_toutSup   (sl_tout_sup),
      .Sl_xferAck   (sl_xfer_ack),
      .user_data_in (udata),
      .user_valid   (uvalid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic void add(input string name, input int op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] exp,
                               input bit uv_ack, input logic [31:0] uv_data);
      vec_t v;
      v.name = name; v.op = op; v.addr = addr; v.data = data; v.exp = exp;
      v.uv_ack = uv_ack; v.uv_data = uv_data;
      vecs.push_back(v);
   endfunction

   task automatic capture(input logic [31:0] d);
      uvalid = 1'b1;
      udata  = d;
      @(posedge clk);
      @(negedge clk);
      uvalid = 1'b0;
   endtask

   // One OPB transfer; optionally raises user_valid so it lands on the ack edge.
   task automatic xfer(input string name, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp,
                       input bit uv_ack, input logic [31:0] uv_data);
      int          lat;
      logic [31:0] got;
      logic [31:0] want;
      abus    = addr;
      rnw     = rd;
      dbus_in = rd ? 32'b0 : wdata;
      select  = 1'b1;
      if (rd) exp_q.push_back(exp);
      lat = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end while (!sl_xfer_ack && lat < 8);
      check({name, " ack latency"}, lat, 32'd1);
      if (rd) begin
         want = exp_q.pop_front();
         if (sl_xfer_ack) begin
            got = sl_dbus;
            check({name, " read data"}, got, want);
         end
      end
      select = 1'b0;
      if (uv_ack) begin
         uvalid = 1'b1;
         udata  = uv_data;
      end
      @(posedge clk);
      @(negedge clk);
      uvalid  = 1'b0;
      dbus_in = 32'b0;
      got = sl_dbus;
      check({name, " idle ack"}, {31'b0, sl_xfer_ack}, 32'd0);
      check({name, " idle dbus"}, got, 32'd0);
   endtask

   task automatic miss(input string name, input logic [31:0] addr);
      logic [31:0] got;
      abus   = addr;
      rnw    = 1'b1;
      select = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = sl_dbus;
         check({name, " no ack"}, {31'b0, sl_xfer_ack}, 32'd0);
         check({name, " dbus"}, got, 32'd0);
      end
      select = 1'b0;
   endtask

   initial begin
      logic [31:0] got;

      // Reset, single capture, overflow, clear and collision scenarios.
      add("rst status",   OpRead,  AStatus, 0, 32'h00000000, 0, 0);
      add("rst data",     OpRead,  AData,   0, 32'h00000000, 0, 0);
      add("cap beef",     OpCap,   0, 32'hDEADBEEF, 0, 0, 0);
      add("status nd",    OpRead,  AStatus, 0, 32'h00000001, 0, 0);
      add("data beef",    OpRead,  AData,   0, 32'hDEADBEEF, 0, 0);
      add("status clr",   OpRead,  AStatus, 0, 32'h00000000, 0, 0);
      add("cap 1",        OpCap,   0, 32'h00000001, 0, 0, 0);
      add("cap 2",        OpCap,   0, 32'h00000002, 0, 0, 0);
      add("cap 3",        OpCap,   0, 32'h00000003, 0, 0, 0);
      add("status ovf2",  OpRead,  AStatus, 0, 32'h00020001, 0, 0);
      add("wr clear",     OpWrite, AStatus, 32'h00000001, 0, 0, 0);
      add("status clrd",  OpRead,  AStatus, 0, 32'h00000001, 0, 0);
      add("data 3",       OpRead,  AData,   0, 32'h00000003, 0, 0);
      add("cap 1111",     OpCap,   0, 32'h11111111, 0, 0, 0);
      add("status pre",   OpRead,  AStatus, 0, 32'h00000001, 0, 0);
      add("data collide", OpRead,  AData,   0, 32'h11111111, 1, 32'h22222222);
      add("status post",  OpRead,  AStatus, 0, 32'h00000001, 0, 0);
      add("data 2222",    OpRead,  AData,   0, 32'h22222222, 0, 0);
      add("status alias", OpRead,  32'h01000B0C, 0, 32'h00000000, 0, 0);
      add("wr data",      OpWrite, AData,   32'hFFFFFFFF, 0, 0, 0);
      add("status wrd",   OpRead,  AStatus, 0, 32'h00000000, 0, 0);
      add("data alias",   OpRead,  32'h01000BF8, 0, 32'h22222222, 0, 0);

      rst_n = 1'b0; abus = 0; be = 0; dbus_in = 0; rnw = 0; select = 0; seq_addr = 0;
      udata = 0; uvalid = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      got = sl_dbus;
      check("reset ack", {31'b0, sl_xfer_ack}, 32'd0);
      check("reset dbus", got, 32'd0);
      check("tied outs", {29'b0, sl_err_ack, sl_retry, sl_tout_sup}, 32'd0);

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OpCap:   capture(vecs[i].data);
            OpRead:  xfer(vecs[i].name, 1'b1, vecs[i].addr, 0, vecs[i].exp,
                          vecs[i].uv_ack, vecs[i].uv_data);
            default: xfer(vecs[i].name, 1'b0, vecs[i].addr, vecs[i].data, 0,
                          vecs[i].uv_ack, vecs[i].uv_data);
         endcase
      end

      // Decode misses just above and below the window.
      miss("miss high", 32'h01000C00);
      miss("miss low", 32'h01000AFC);

      // Select held for six cycles: acks alternate, status shows new_data.
      capture(32'h00000005);
      abus = AStatus; rnw = 1'b1; select = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         got = sl_dbus;
         check($sformatf("held ack %0d", i), {31'b0, sl_xfer_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("held dbus %0d", i), got, (i % 2 == 0) ? 32'h1 : 32'h0);
      end
      select = 1'b0;
      @(negedge clk);

      // Saturation, then a clear write racing an overflow event.
      uvalid = 1'b1;
      udata  = 32'hA5A5A5A5;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      uvalid = 1'b0;
      xfer("status sat", 1'b1, AStatus, 0, 32'hFFFF0001, 0, 0);
      xfer("wr race", 1'b0, AStatus, 32'h00000001, 0, 1, 32'h00000077);
      xfer("status race", 1'b1, AStatus, 0, 32'h00010001, 0, 0);
      xfer("data race", 1'b1, AData, 0, 32'h00000077, 0, 0);

      // Asynchronous reset clears everything without a clock edge.
      capture(32'h12345678);
      #2 rst_n = 1'b0;
      #1 got = sl_dbus;
      check("async rst dbus", got, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer("post rst status", 1'b1, AStatus, 0, 32'h00000000, 0, 0);
      xfer("post rst data", 1'b1, AData, 0, 32'h00000000, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
OPB slave that carries data from the Simulink fabric up to the PowerPC, in the opposite direction to the ppc2simulink control registers. User logic presents a 32-bit word with a valid strobe. The block holds the latest word and exposes it to the OPB with a sticky new-data flag and a saturating overflow counter. It sits on the same OPB as the other software registers and uses one clock, OPB_Clk.

Parameters:
C_BASEADDR, 32'h01000B00, first byte address decoded
C_HIGHADDR, 32'h01000BFF, last byte address decoded
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_FAMILY, "virtex5", target family; no functional effect

Ports:
OPB_Clk  in  1  single clock for OPB and user sides
OPB_Rst_n  in  1  reset, asynchronous assert, active-low
OPB_ABus  in  [0:31]  address, big-endian bit order
OPB_BE  in  [0:3]  byte enables; ignored
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; all zero except in a read-ack cycle
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_in  in  [31:0]  fabric data
user_valid  in  1  capture strobe for user_data_in

Behaviour:
- Reset (OPB_Rst_n low, asynchronous): FSM goes to IDLE. hold_reg, new_data, ovf_cnt and all outputs are cleared to 0. Reset mid-transfer abandons the ack; the master times out.
- Bit mapping: Sl_DBus[0] = value[31] and Sl_DBus[31] = value[0]. OPB_DBus uses the same mapping.
- Decode: hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The word is selected by OPB_ABus[29]. 0 selects DATA (offset 0x0) and 1 selects STATUS (offset 0x4). Words alias every 8 bytes across the range.
- FSM states IDLE and ACK:
  - IDLE: if hit, latch RNW and the word select, then go to ACK.
  - ACK: Sl_xferAck = 1 for exactly one cycle, then return to IDLE.
  - Latency is fixed: ack arrives one cycle after select is sampled with a hit. If select is held high, acks repeat every second cycle. No ack is ever issued without a hit.
- Read DATA: Sl_DBus = hold_reg in the ACK cycle. new_data clears at the end of the ACK cycle.
- Read STATUS: value = {ovf_cnt[15:0], 15'b0, new_data}. No side effects.
- Write DATA: acknowledged, no effect.
- Write STATUS: if written value bit0 = 1, ovf_cnt clears to 0. Other bits are ignored.
- Capture: when user_valid = 1, hold_reg <= user_data_in and new_data <= 1 on the next edge.
- Overflow: if user_valid = 1 and new_data = 1 and no DATA read-ack occurs this cycle, ovf_cnt increments. ovf_cnt saturates at 16'hFFFF.
- Simultaneous events:
  - user_valid in the same cycle as a DATA read-ack: the read returns the old hold_reg. hold_reg takes the new word and new_data ends at 1. ovf_cnt does not increment.
  - user_valid with an overflow condition in the same cycle as a STATUS clear write: ovf_cnt ends at 1, so the event is not lost.
- Sl_DBus is registered and forced to 0 outside read-ack cycles so it can be OR-ed onto the OPB.

Test Plan:
- Reset check -> immediately after OPB_Rst_n rises, STATUS read returns 0x00000000 and DATA read returns 0x00000000. Sl_xferAck and Sl_DBus are 0 while idle.
- Single capture -> user_valid pulse with 0xDEADBEEF. STATUS reads 0x00000001 and DATA reads 0xDEADBEEF with ack one cycle after select. A second STATUS read returns 0x00000000.
- Overflow -> 3 user_valid pulses (0x1, 0x2, 0x3) with no reads. STATUS = 0x00020001 and DATA = 0x00000003. A STATUS write of 0x00000001 gives STATUS = 0x00000001.
- Collision -> hold_reg = 0x11111111 and new_data = 1. user_valid with 0x22222222 lands on the DATA read-ack cycle. The read returns 0x11111111, STATUS = 0x00000001 (count unchanged), and the next DATA read returns 0x22222222.
- Decode -> select at 0x01000C00 gives no ack and Sl_DBus = 0. Select at 0x01000B0C returns STATUS (alias). Select held high for 6 cycles gives acks on cycles 2, 4 and 6.
- Saturation and clear race -> force 65540 overflow events; STATUS[31:16] = 0xFFFF. A clear write coinciding with an overflow event gives STATUS[31:16] = 0x0001.
